// File: rtl/lane_combat_ctrl.sv
// Lane combat round controller: decides per game tick whether two opposing
// units fight or advance, and applies siege damage to the base health counters.
module lane_combat_ctrl #(
    parameter int RANGE   = 4,
    parameter int POS_MAX = 511,
    parameter int BASE_HP = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_tick,
    input  logic [8:0] ally_pos,
    input  logic [8:0] enemy_pos,
    input  logic [7:0] ally_dmg,
    input  logic [7:0] enemy_dmg,
    input  logic       ally_alive,
    input  logic       enemy_alive,
    output logic       ally_move_scen,
    output logic       enemy_move_scen,
    output logic       ally_dmg_scen,
    output logic       enemy_dmg_scen,
    output logic [7:0] ally_dmg_in,
    output logic [7:0] enemy_dmg_in,
    output logic [7:0] ally_base_hp,
    output logic [7:0] enemy_base_hp,
    output logic       game_over,
    output logic       tick_overrun
);

    localparam logic [8:0] RANGE_L   = 9'(RANGE);
    localparam logic [8:0] POS_MAX_L = 9'(POS_MAX);
    localparam logic [7:0] BASE_HP_L = 8'(BASE_HP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        ACT  = 2'd2
    } state_t;

    state_t     state_r;
    logic [8:0] ally_pos_r, enemy_pos_r;
    logic [7:0] ally_dmg_r, enemy_dmg_r;
    logic       ally_alive_r, enemy_alive_r;
    logic       ally_siege_r, enemy_siege_r;
    logic       ally_move_r, enemy_move_r, ally_hit_r, enemy_hit_r;
    logic [7:0] ally_dmg_in_r, enemy_dmg_in_r;
    logic [7:0] ally_base_hp_r, enemy_base_hp_r;
    logic       game_over_r, tick_overrun_r;

    logic [8:0] gap_s;
    logic       fight_s, ally_move_s, enemy_move_s, ally_siege_s, enemy_siege_s;

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

    // Round decision from the captured snapshot; crossed units count as touching.
    always_comb begin
        gap_s = 9'd0;
        if (enemy_pos_r >= ally_pos_r) begin
            gap_s = enemy_pos_r - ally_pos_r;
        end else begin
            gap_s = 9'd0;
        end
        fight_s       = ally_alive_r && enemy_alive_r && (gap_s <= RANGE_L);
        ally_move_s   = !fight_s && ally_alive_r && (ally_pos_r != POS_MAX_L);
        enemy_move_s  = !fight_s && enemy_alive_r && (enemy_pos_r != 9'd0);
        ally_siege_s  = ally_alive_r && !enemy_alive_r && (ally_pos_r == POS_MAX_L);
        enemy_siege_s = enemy_alive_r && !ally_alive_r && (enemy_pos_r == 9'd0);
    end

    // Round FSM with registered strobes, base counters and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            ally_pos_r      <= 9'd0;
            enemy_pos_r     <= 9'd0;
            ally_dmg_r      <= 8'd0;
            enemy_dmg_r     <= 8'd0;
            ally_alive_r    <= 1'b0;
            enemy_alive_r   <= 1'b0;
            ally_siege_r    <= 1'b0;
            enemy_siege_r   <= 1'b0;
            ally_move_r     <= 1'b0;
            enemy_move_r    <= 1'b0;
            ally_hit_r      <= 1'b0;
            enemy_hit_r     <= 1'b0;
            ally_dmg_in_r   <= 8'd0;
            enemy_dmg_in_r  <= 8'd0;
            ally_base_hp_r  <= BASE_HP_L;
            enemy_base_hp_r <= BASE_HP_L;
            game_over_r     <= 1'b0;
            tick_overrun_r  <= 1'b0;
        end else begin
            ally_move_r    <= 1'b0;
            enemy_move_r   <= 1'b0;
            ally_hit_r     <= 1'b0;
            enemy_hit_r    <= 1'b0;
            ally_dmg_in_r  <= 8'd0;
            enemy_dmg_in_r <= 8'd0;
            if ((ally_base_hp_r == 8'd0) || (enemy_base_hp_r == 8'd0)) begin
                game_over_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (game_tick && !game_over_r) begin
                        ally_pos_r    <= ally_pos;
                        enemy_pos_r   <= enemy_pos;
                        ally_dmg_r    <= ally_dmg;
                        enemy_dmg_r   <= enemy_dmg;
                        ally_alive_r  <= ally_alive;
                        enemy_alive_r <= enemy_alive;
                        state_r       <= EVAL;
                    end
                end
                EVAL: begin
                    if (game_tick && !game_over_r) begin
                        tick_overrun_r <= 1'b1;
                    end
                    ally_siege_r   <= ally_siege_s;
                    enemy_siege_r  <= enemy_siege_s;
                    ally_move_r    <= ally_move_s;
                    enemy_move_r   <= enemy_move_s;
                    ally_hit_r     <= fight_s;
                    enemy_hit_r    <= fight_s;
                    ally_dmg_in_r  <= fight_s ? enemy_dmg_r : 8'd0;
                    enemy_dmg_in_r <= fight_s ? ally_dmg_r : 8'd0;
                    state_r        <= ACT;
                end
                ACT: begin
                    if (game_tick && !game_over_r) begin
                        tick_overrun_r <= 1'b1;
                    end
                    if (ally_siege_r) begin
                        enemy_base_hp_r <= sat_sub(enemy_base_hp_r, ally_dmg_r);
                    end
                    if (enemy_siege_r) begin
                        ally_base_hp_r <= sat_sub(ally_base_hp_r, enemy_dmg_r);
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign ally_move_scen  = ally_move_r;
    assign enemy_move_scen = enemy_move_r;
    assign ally_dmg_scen   = ally_hit_r;
    assign enemy_dmg_scen  = enemy_hit_r;
    assign ally_dmg_in     = ally_dmg_in_r;
    assign enemy_dmg_in    = enemy_dmg_in_r;
    assign ally_base_hp    = ally_base_hp_r;
    assign enemy_base_hp   = enemy_base_hp_r;
    assign game_over       = game_over_r;
    assign tick_overrun    = tick_overrun_r;

endmodule

// File: tb/tb_lane_combat_ctrl.sv
// Scoreboard bench for lane_combat_ctrl: expected round results are queued at
// tick time and compared in the ACT cycle and after the round.
module tb_lane_combat_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       game_tick;
    logic [8:0] ally_pos, enemy_pos;
    logic [7:0] ally_dmg, enemy_dmg;
    logic       ally_alive, enemy_alive;
    logic       ally_move_scen, enemy_move_scen, ally_dmg_scen, enemy_dmg_scen;
    logic [7:0] ally_dmg_in, enemy_dmg_in, ally_base_hp, enemy_base_hp;
    logic       game_over, tick_overrun;

    lane_combat_ctrl dut (
        .clk(clk), .reset(reset), .game_tick(game_tick),
        .ally_pos(ally_pos), .enemy_pos(enemy_pos),
        .ally_dmg(ally_dmg), .enemy_dmg(enemy_dmg),
        .ally_alive(ally_alive), .enemy_alive(enemy_alive),
        .ally_move_scen(ally_move_scen), .enemy_move_scen(enemy_move_scen),
        .ally_dmg_scen(ally_dmg_scen), .enemy_dmg_scen(enemy_dmg_scen),
        .ally_dmg_in(ally_dmg_in), .enemy_dmg_in(enemy_dmg_in),
        .ally_base_hp(ally_base_hp), .enemy_base_hp(enemy_base_hp),
        .game_over(game_over), .tick_overrun(tick_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       am, em, ad, ed;
        logic [7:0] adi, edi;
        logic [7:0] ahp, ehp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] m_ahp, m_ehp;
    logic       m_go, m_ovr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ahp = 8'd255;
        m_ehp = 8'd255;
        m_go  = 1'b0;
        m_ovr = 1'b0;
        sb_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_strobes"}, {ally_move_scen, enemy_move_scen, ally_dmg_scen, enemy_dmg_scen}, 4'd0);
        check_val({tag, "_dmg_in"}, {ally_dmg_in, enemy_dmg_in}, 16'd0);
    endtask

    // One full round: tick, optional second tick in EVAL, ACT check, base and flag checks.
    task automatic run_round(input string tag, input logic [8:0] ap, input logic [8:0] ep,
                             input logic [7:0] ad, input logic [7:0] ed,
                             input logic aa, input logic ea, input logic dbl);
        exp_t e;
        int   gap;
        logic fight;
        @(negedge clk);
        ally_pos = ap; enemy_pos = ep; ally_dmg = ad; enemy_dmg = ed;
        ally_alive = aa; enemy_alive = ea; game_tick = 1'b1;
        e.am = 1'b0; e.em = 1'b0; e.ad = 1'b0; e.ed = 1'b0; e.adi = 8'd0; e.edi = 8'd0;
        if (!m_go) begin
            gap   = (ep >= ap) ? (int'(ep) - int'(ap)) : 0;
            fight = aa && ea && (gap <= 4);
            e.ad  = fight;
            e.ed  = fight;
            e.adi = fight ? ed : 8'd0;
            e.edi = fight ? ad : 8'd0;
            e.am  = !fight && aa && (ap != 9'd511);
            e.em  = !fight && ea && (ep != 9'd0);
            if (aa && !ea && ap == 9'd511) m_ehp = (m_ehp > ad) ? m_ehp - ad : 8'd0;
            if (ea && !aa && ep == 9'd0)   m_ahp = (m_ahp > ed) ? m_ahp - ed : 8'd0;
            if (dbl) m_ovr = 1'b1;
        end
        e.ahp = m_ahp;
        e.ehp = m_ehp;
        sb_q.push_back(e);
        @(negedge clk);
        game_tick = dbl;
        @(negedge clk);
        game_tick = 1'b0;
        e = sb_q.pop_front();
        check_val({tag, "_ally_move"},  ally_move_scen,  e.am);
        check_val({tag, "_enemy_move"}, enemy_move_scen, e.em);
        check_val({tag, "_dmg_scen"},   {ally_dmg_scen, enemy_dmg_scen}, {e.ad, e.ed});
        check_val({tag, "_ally_dmg_in"},  ally_dmg_in,  e.adi);
        check_val({tag, "_enemy_dmg_in"}, enemy_dmg_in, e.edi);
        @(negedge clk);
        check_idle_outputs({tag, "_post"});
        check_val({tag, "_ally_hp"},  ally_base_hp,  e.ahp);
        check_val({tag, "_enemy_hp"}, enemy_base_hp, e.ehp);
        if (m_ahp == 8'd0 || m_ehp == 8'd0) m_go = 1'b1;
        @(negedge clk);
        check_val({tag, "_game_over"}, game_over, m_go);
        check_val({tag, "_overrun"}, tick_overrun, m_ovr);
    endtask

    initial begin
        reset = 1'b1; game_tick = 1'b0;
        ally_pos = 9'd0; enemy_pos = 9'd0; ally_dmg = 8'd0; enemy_dmg = 8'd0;
        ally_alive = 1'b0; enemy_alive = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        check_val("rst_hp", {ally_base_hp, enemy_base_hp}, 16'hFFFF);
        check_val("rst_flags", {game_over, tick_overrun}, 2'b00);
        reset = 1'b0;

        run_round("move",      9'd10,  9'd20, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0);
        run_round("fight",     9'd10,  9'd13, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
        run_round("crossed",   9'd12,  9'd10, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
        run_round("gap_range", 9'd10,  9'd14, 8'h05, 8'h06, 1'b1, 1'b1, 1'b0);
        run_round("gap_out",   9'd10,  9'd15, 8'h05, 8'h06, 1'b1, 1'b1, 1'b0);
        run_round("ally_only", 9'd100, 9'd0,  8'h07, 8'h08, 1'b1, 1'b0, 1'b0);
        run_round("both_dead", 9'd10,  9'd20, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        run_round("e_siege",   9'd511, 9'd5,  8'h30, 8'h44, 1'b1, 1'b0, 1'b0);
        run_round("a_siege",   9'd40,  9'd0,  8'h12, 8'h40, 1'b0, 1'b1, 1'b0);
        check_val("a_siege_191", ally_base_hp, 8'd191);
        run_round("a_siege2",  9'd40,  9'd0,  8'h12, 8'hAF, 1'b0, 1'b1, 1'b0);
        check_val("a_siege_16", ally_base_hp, 8'h10);
        run_round("a_sat",     9'd40,  9'd0,  8'h12, 8'h80, 1'b0, 1'b1, 1'b0);
        run_round("after_over", 9'd10, 9'd20, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0);

        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        model_reset();
        run_round("overrun",   9'd10,  9'd20, 8'h11, 8'h22, 1'b1, 1'b1, 1'b1);
        run_round("pre_abort", 9'd40,  9'd0,  8'h12, 8'h40, 1'b0, 1'b1, 1'b0);

        // Start a moving round and assert reset in its ACT cycle.
        @(negedge clk);
        ally_pos = 9'd10; enemy_pos = 9'd30; ally_alive = 1'b1; enemy_alive = 1'b1;
        game_tick = 1'b1;
        @(negedge clk); game_tick = 1'b0;
        @(negedge clk);
        check_val("abort_act_move", {ally_move_scen, enemy_move_scen}, 2'b11);
        reset = 1'b1;
        #1;
        check_idle_outputs("abort");
        check_val("abort_hp", {ally_base_hp, enemy_base_hp}, 16'hFFFF);
        check_val("abort_flags", {game_over, tick_overrun}, 2'b00);
        @(negedge clk);
        check_idle_outputs("abort_next");
        reset = 1'b0;
        model_reset();
        run_round("post_abort", 9'd10, 9'd20, 8'h11, 8'h22, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
